// File: rtl/aes_uart_pkg.sv
// Shared types for the UART-to-AES front end: block geometry, packer FSM
// states and a byte-lane helper used by the packer.
package aes_uart_pkg;

  localparam int BLOCK_BYTES = 16;

  typedef logic [8*BLOCK_BYTES-1:0] block_t;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FILL  = 2'd1,
    S_FULL  = 2'd2
  } pack_state_e;

  // Write byte d into lane idx of a block; lane 0 is the most significant byte.
  function automatic block_t put_byte(block_t b, logic [3:0] idx, logic [7:0] d);
    block_t r;
    r = b;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      if (idx == 4'(k)) r[8*BLOCK_BYTES-1-8*k -: 8] = d;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_block_packer.sv
// Packs received UART bytes big-endian into 16-byte blocks for the CTR
// encryptor. A partial block is flushed after TIMEOUT_CYCLES idle clocks.
// One assembly register feeds one output holding register (valid/ready).
module uart_block_packer
  import aes_uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [7:0]   rx_data,
  input  logic         rx_valid,
  output logic [127:0] blk_data,
  output logic [4:0]   blk_bytes,
  output logic         blk_valid,
  input  logic         blk_ready,
  output logic         overrun,
  input  logic         clr_err
);

  localparam int            TW  = 20;
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);

  pack_state_e   state_q, state_d;
  logic [4:0]    cnt_q, cnt_d;
  block_t        asm_q, asm_d;
  logic [TW-1:0] tmr_q, tmr_d;
  block_t        out_data_q, out_data_d;
  logic [4:0]    out_bytes_q, out_bytes_d;
  logic          out_vld_q, out_vld_d;
  logic          ovr_q, ovr_d;

  logic          out_free;
  logic [TW-1:0] tmr_inc;

  // Next-state: byte acceptance, full-block transfer, timeout flush, overrun.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    tmr_d       = tmr_q;
    out_data_d  = out_data_q;
    out_bytes_d = out_bytes_q;
    out_vld_d   = out_vld_q;
    ovr_d       = ovr_q;

    // Holding register can take a new block if empty or being drained now.
    out_free = !out_vld_q || blk_ready;
    tmr_inc  = (tmr_q == TMO) ? tmr_q : tmr_q + TW'(1);

    if (out_vld_q && blk_ready) out_vld_d = 1'b0;
    // Clear first so a same-cycle drop below wins.
    if (clr_err) ovr_d = 1'b0;

    case (state_q)
      S_EMPTY: begin
        if (rx_valid) begin
          asm_d   = put_byte('0, 4'd0, rx_data);
          cnt_d   = 5'd1;
          tmr_d   = '0;
          state_d = S_FILL;
        end
      end

      S_FILL: begin
        if (rx_valid) begin
          // A new byte always wins over a pending flush and restarts the timer.
          asm_d = put_byte(asm_q, cnt_q[3:0], rx_data);
          cnt_d = cnt_q + 5'd1;
          tmr_d = '0;
          if (cnt_q == 5'd15) state_d = S_FULL;
        end else begin
          tmr_d = tmr_inc;
          // Saturated timer keeps the flush pending until the output frees up.
          if (tmr_inc == TMO && out_free) begin
            out_data_d  = asm_q;
            out_bytes_d = cnt_q;
            out_vld_d   = 1'b1;
            asm_d       = '0;
            cnt_d       = '0;
            tmr_d       = '0;
            state_d     = S_EMPTY;
          end
        end
      end

      S_FULL: begin
        tmr_d = '0;
        if (out_free) begin
          out_data_d  = asm_q;
          out_bytes_d = 5'd16;
          out_vld_d   = 1'b1;
          if (rx_valid) begin
            // Coincident byte starts the next block in the emptied register.
            asm_d   = put_byte('0, 4'd0, rx_data);
            cnt_d   = 5'd1;
            state_d = S_FILL;
          end else begin
            asm_d   = '0;
            cnt_d   = '0;
            state_d = S_EMPTY;
          end
        end else if (rx_valid) begin
          ovr_d = 1'b1;
        end
      end

      default: begin
        asm_d   = '0;
        cnt_d   = '0;
        tmr_d   = '0;
        state_d = S_EMPTY;
      end
    endcase
  end

  // State registers; reset discards any partial or held block.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_EMPTY;
      cnt_q       <= '0;
      asm_q       <= '0;
      tmr_q       <= '0;
      out_data_q  <= '0;
      out_bytes_q <= '0;
      out_vld_q   <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      tmr_q       <= tmr_d;
      out_data_q  <= out_data_d;
      out_bytes_q <= out_bytes_d;
      out_vld_q   <= out_vld_d;
      ovr_q       <= ovr_d;
    end
  end

  assign blk_data  = out_data_q;
  assign blk_bytes = out_bytes_q;
  assign blk_valid = out_vld_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_uart_block_packer.sv
// Bench for uart_block_packer: table of byte streams with expected blocks,
// plus hand sequences for backpressure, overrun, coincident transfer, reset.
module tb_uart_block_packer;

  localparam int TMO = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic [127:0] blk_data;
  logic [4:0]   blk_bytes;
  logic         blk_valid;
  logic         blk_ready;
  logic         overrun;
  logic         clr_err;

  uart_block_packer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .blk_data(blk_data), .blk_bytes(blk_bytes), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .overrun(overrun), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int last_cyc = 0;
  int rise_cyc = 0;
  logic vld_prev = 1'b0;

  typedef struct {
    logic [127:0] data;
    logic [4:0]   bytes;
  } exp_t;
  exp_t sbq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Scoreboard: compare every handshaken block against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (reset && blk_valid && blk_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_block: got %h/%0d want none", blk_data, blk_bytes);
      end else begin
        e = sbq.pop_front();
        chk("blk_data", blk_data, e.data);
        chk("blk_bytes", 128'(blk_bytes), 128'(e.bytes));
      end
    end
  end

  // Cycle of each blk_valid rising edge, for latency checks.
  always @(negedge clk) begin
    if (blk_valid && !vld_prev) rise_cyc <= cyc;
    vld_prev <= blk_valid;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle strobe; called just after a rising edge.
  task automatic send(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    last_cyc = cyc;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_ramp(input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) send(base + 8'(k));
  endtask

  task automatic wait_drain;
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errs++;
      $display("FAIL drain_timeout: got %0d pending want 0", sbq.size());
      sbq.delete();
    end
  endtask

  // 16 incrementing bytes, assembled by shifting in arrival order.
  function automatic logic [127:0] ramp(input logic [7:0] b);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r = {r[119:0], b + 8'(k)};
    return r;
  endfunction

  typedef struct {
    int           n;
    logic [7:0]   base;
    logic [7:0]   step;
    int           gap;
    logic [127:0] exp_data;
    logic [4:0]   exp_bytes;
    int           exp_lat;
  } vec_t;
  vec_t tv[5];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;

    tv[0] = '{16, 8'h00, 8'h01, 4, 128'h000102030405060708090A0B0C0D0E0F, 5'd16, 2};
    tv[1] = '{3,  8'hAA, 8'h11, 4, 128'hAABBCC00_0000_0000_0000_0000_0000_0000, 5'd3, 11};
    tv[2] = '{16, 8'h10, 8'h01, 1, 128'h101112131415161718191A1B1C1D1E1F, 5'd16, 2};
    tv[3] = '{5,  8'hF0, 8'h02, 2, 128'hF0F2F4F6F8_000000_0000000000000000, 5'd5, 11};
    tv[4] = '{1,  8'h5A, 8'h00, 1, 128'h5A00_0000_0000_0000_0000_0000_0000_0000, 5'd1, 11};

    reset = 1'b0; rx_valid = 1'b0; rx_data = '0; blk_ready = 1'b1; clr_err = 1'b0;
    idle(2);
    chk("rst_valid", 128'(blk_valid), 128'(0));
    chk("rst_data", blk_data, 128'(0));
    chk("rst_bytes", 128'(blk_bytes), 128'(0));
    chk("rst_overrun", 128'(overrun), 128'(0));
    reset = 1'b1;
    idle(2);

    // Table-driven streams with blk_ready held high.
    for (int i = 0; i < 5; i++) begin
      sbq.push_back('{tv[i].exp_data, tv[i].exp_bytes});
      d = tv[i].base;
      for (int j = 0; j < tv[i].n; j++) begin
        send(d);
        idle(tv[i].gap - 1);
        d = d + tv[i].step;
      end
      wait_drain();
      chk("latency", 128'(rise_cyc - last_cyc), 128'(tv[i].exp_lat));
      chk("valid_pulse", 128'(blk_valid), 128'(0));
    end

    // Backpressure: held block, stalled second block, dropped 33rd byte.
    blk_ready = 1'b0;
    send_ramp(8'h20, 16);
    idle(2);
    chk("held_valid", 128'(blk_valid), 128'(1));
    chk("held_data", blk_data, ramp(8'h20));
    send_ramp(8'h30, 16);
    idle(2);
    chk("stall_overrun", 128'(overrun), 128'(0));
    chk("stall_data", blk_data, ramp(8'h20));
    clr_err = 1'b1;
    send(8'h40);
    clr_err = 1'b0;
    chk("ovr_set_prio", 128'(overrun), 128'(1));
    chk("held_data2", blk_data, ramp(8'h20));
    chk("held_bytes", 128'(blk_bytes), 128'(16));
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    chk("ovr_cleared", 128'(overrun), 128'(0));
    sbq.push_back('{ramp(8'h20), 5'd16});
    sbq.push_back('{ramp(8'h30), 5'd16});
    blk_ready = 1'b1;
    wait_drain();
    idle(TMO + 5);
    chk("no_third_block", 128'(blk_valid), 128'(0));

    // Release backpressure in the same cycle as a byte on a full assembly.
    blk_ready = 1'b0;
    send_ramp(8'h50, 16);
    idle(2);
    send_ramp(8'h60, 16);
    idle(2);
    sbq.push_back('{ramp(8'h50), 5'd16});
    sbq.push_back('{ramp(8'h60), 5'd16});
    sbq.push_back('{128'h7000_0000_0000_0000_0000_0000_0000_0000, 5'd1});
    blk_ready = 1'b1;
    send(8'h70);
    chk("coinc_overrun", 128'(overrun), 128'(0));
    wait_drain();
    chk("coinc_overrun2", 128'(overrun), 128'(0));

    // Reset with a held block and a partial block in assembly.
    blk_ready = 1'b0;
    send_ramp(8'h90, 16);
    idle(2);
    send_ramp(8'hA0, 7);
    chk("pre_rst_valid", 128'(blk_valid), 128'(1));
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(blk_valid), 128'(0));
    chk("mid_rst_data", blk_data, 128'(0));
    chk("mid_rst_bytes", 128'(blk_bytes), 128'(0));
    chk("mid_rst_overrun", 128'(overrun), 128'(0));
    idle(2);
    reset = 1'b1;
    idle(TMO + 5);
    chk("post_rst_quiet", 128'(blk_valid), 128'(0));
    blk_ready = 1'b1;
    sbq.push_back('{ramp(8'h80), 5'd16});
    send_ramp(8'h80, 16);
    wait_drain();
    chk("post_rst_latency", 128'(rise_cyc - last_cyc), 128'(2));

    idle(3);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/uart_block_packer.md
UART_BLOCK_PACKER -- requirements
Module: uart_block_packer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000: idle clocks after the last byte before a partial block is flushed; legal range 1..2^20-1.
REQ-002 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port rx_data, input, 8: received UART byte.
REQ-005 SHALL have port rx_valid, input, 1: single-cycle strobe qualifying rx_data.
REQ-006 SHALL have port blk_data, output, 128: assembled plaintext block for the CTR encryptor.
REQ-007 SHALL have port blk_bytes, output, 5: count of real bytes in blk_data, 1..16.
REQ-008 SHALL have port blk_valid, output, 1: blk_data and blk_bytes are valid.
REQ-009 SHALL have port blk_ready, input, 1: consumer accepts the block; transfer occurs when blk_valid and blk_ready are both 1.
REQ-010 SHALL have port overrun, output, 1: sticky flag, set when a byte is dropped.
REQ-011 SHALL have port clr_err, input, 1: synchronous clear of overrun.

Function
REQ-012 SHALL pack bytes big-endian: byte k of a block (k = 0..15, arrival order) goes to blk_data[127-8k -: 8].
REQ-013 SHALL contain an assembly register with a byte count of 0..16 and an output holding register with a valid bit (blk_valid).
REQ-014 SHALL accept rx_data into the assembly register on rx_valid when count < 16, then increment count.
REQ-015 SHALL move the assembly register to the output register, with blk_bytes=16, on the cycle when count==16 and the output register is free. Free means blk_valid==0 or a handshake occurs in the same cycle. Count then returns to 0.
REQ-016 SHALL therefore assert blk_valid exactly 2 clocks after the rx_valid cycle of the 16th byte when the output register is free (one clock to write the byte, one to transfer).
REQ-017 SHALL hold blk_data, blk_bytes and blk_valid stable while blk_valid==1 and blk_ready==0.
REQ-018 SHALL run an idle timer only when 0 < count < 16. The timer clears on any accepted byte and saturates at TIMEOUT_CYCLES.
REQ-019 SHALL flush a partial block when the timer reaches TIMEOUT_CYCLES and the output register is free. The flush zero-fills unused low bytes, sets blk_bytes = count, and clears both count and the timer.
REQ-020 SHALL keep a saturated timer's flush pending while the output register is full. A byte that arrives in that interval is appended and restarts the timer.
REQ-021 SHALL drop rx_data when rx_valid arrives with count==16 and the transfer cannot occur that cycle, and SHALL set overrun.
REQ-022 SHALL accept the new byte into a freshly emptied assembly register when rx_valid coincides with a 16-byte transfer in the same cycle. The byte becomes byte 0 of the next block, count=1, and overrun is not set.
REQ-023 SHALL give priority to setting overrun when a set event and clr_err coincide.
REQ-024 SHALL implement the state machine S_EMPTY (count 0), S_FILL (0<count<16), S_FULL (count 16, awaiting the output register), with transitions:
- S_EMPTY -> S_FILL on a byte.
- S_FILL -> S_FULL on the 16th byte.
- S_FILL -> S_EMPTY on a flush.
- S_FULL -> S_EMPTY on transfer.
- S_FULL -> S_FILL on transfer plus a coincident byte.

Reset
REQ-025 SHALL, while reset==0, asynchronously force: blk_valid=0, blk_data=0, blk_bytes=0, overrun=0, count=0, timer=0, state S_EMPTY.
REQ-026 SHALL discard any partial or held block when reset asserts mid-operation; nothing is emitted after reset release until new bytes arrive.

Structure
REQ-027 SHALL take BLOCK_BYTES=16, the state enum type and the 128-bit block typedef from the shared package aes_uart_pkg.
REQ-028 SHALL be a single module with no sub-modules; the timer and FSM are inline.

Verification
REQ-029 Bytes 0x00..0x0F strobed every 4 clocks with blk_ready=1 -> blk_data=128'h000102030405060708090A0B0C0D0E0F, blk_bytes=16, blk_valid for 1 clock, 2 clocks after the last strobe.
REQ-030 3 bytes 0xAA,0xBB,0xCC, then idle with TIMEOUT_CYCLES=10 -> blk_data=128'hAABBCC00..00, blk_bytes=3, blk_valid rises 11 clocks after the last byte.
REQ-031 blk_ready=0, 33 bytes sent -> first block held stable, second block stalls at count 16, 33rd byte dropped, overrun=1; clr_err pulse -> overrun=0.
REQ-032 blk_ready=0 with a full output register, then blk_ready=1 in the same cycle as a rx_valid on a full assembly -> both blocks delivered in order, new byte is byte 0 of the third block, overrun stays 0.
REQ-033 reset pulled low after 7 bytes and a held block -> all outputs 0 immediately; after release, 16 new bytes produce one correct block.
